// File: rtl/serial_pkg.sv
// Shared definitions for the serial block transmitter.
//   - txState_t : transmitter FSM encoding
//   - UART framing constants and the default bit period (50 MHz / 115200)
//   - evenParity: parity bit that makes the count of ones in data+parity even
// Optional feature macro: SERIAL_BLOCK_TX_PARITY_EN adds the PARITY state.
package serial_pkg;

   localparam int   CLKS_PER_BIT_DEFAULT = 434;
   localparam int   UART_DATA_BITS       = 8;
   localparam logic UART_START_BIT       = 1'b0;
   localparam logic UART_STOP_BIT        = 1'b1;

`ifdef SERIAL_BLOCK_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } txState_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4,
      DONE   = 3'd5
   } txState_t;
`endif

   function automatic logic evenParity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for the serial transmitter.
// Down-counter that pulses tick for one cycle when it reaches zero and
// reloads in the same cycle, so consecutive bits have no slip cycle.
//   Clk   in  system clock
//   Rst   in  synchronous active-high reset (counter to 0)
//   clear in  restart the period; the next tick follows CLKS_PER_BIT cycles later
//   tick  out one-cycle pulse in the last cycle of each bit period
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt <= '0;
      end else if (clear || (cnt == '0)) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/serial_block_tx.sv
// Block UART transmitter answering the controller's write handshake.
// Captures DataIn while SerialWriteEn is high and sends it as NUM_BYTES
// frames, most significant byte first, each byte LSB first.
//   Clk           in  system clock
//   Rst           in  synchronous active-high reset
//   SerialWriteEn in  level request, held for the controller's write state
//   DataIn        in  block to send, sampled only at capture
//   Tx            out UART line, idles high
//   SerialWriteRy out block sent; held while SerialWriteEn stays high
//   Busy          out high from capture until the last stop bit ends
// Optional feature macro: SERIAL_BLOCK_TX_PARITY_EN (even parity bit per frame).
//
// state  | meaning
// IDLE   | waiting for SerialWriteEn, line high
// START  | start bit of current byte
// DATA   | data bit bitIdx of current byte
// PARITY | even-parity bit (parity build only)
// STOP   | stop bit; picks next byte, DONE or IDLE
// DONE   | block sent, holding SerialWriteRy until enable drops
module serial_block_tx
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int NUM_BYTES    = 16
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   SerialWriteEn,
   input  logic [8*NUM_BYTES-1:0] DataIn,
   output logic                   Tx,
   output logic                   SerialWriteRy,
   output logic                   Busy
);

   localparam int BLOCK_W = 8 * NUM_BYTES;
   localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   txState_t             state, stateNext;
   logic                 tick;
   logic                 capture;
   logic                 lastByte;
   logic                 lastBit;
   logic [BLOCK_W-1:0]   shiftReg;
   logic [IDX_W-1:0]     byteIdx;
   logic [2:0]           bitIdx;
   logic [7:0]           curByte;
   logic                 txNext;
   logic                 ryNext;
   logic                 busyNext;

   assign capture  = (state == IDLE) && SerialWriteEn;
   assign curByte  = shiftReg[BLOCK_W-1 -: 8];
   assign lastByte = (byteIdx == IDX_W'(NUM_BYTES - 1));
   assign lastBit  = (bitIdx == 3'(UART_DATA_BITS - 1));

   // Clearing at capture aligns the first bit period to the capture edge.
   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) uBaud (
      .Clk   (Clk),
      .Rst   (Rst),
      .clear (capture),
      .tick  (tick)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (SerialWriteEn) stateNext = START;
         end
         START: begin
            if (tick) stateNext = DATA;
         end
         DATA: begin
            if (tick && lastBit) begin
`ifdef SERIAL_BLOCK_TX_PARITY_EN
               stateNext = PARITY;
`else
               stateNext = STOP;
`endif
            end
         end
`ifdef SERIAL_BLOCK_TX_PARITY_EN
         PARITY: begin
            if (tick) stateNext = STOP;
         end
`endif
         STOP: begin
            // A dropped enable lets the current frame finish, then abandons the block.
            if (tick) begin
               if (!SerialWriteEn) begin
                  stateNext = IDLE;
               end else if (!lastByte) begin
                  stateNext = START;
               end else begin
                  stateNext = DONE;
               end
            end
         end
         DONE: begin
            if (!SerialWriteEn) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Outputs are registered from the current state, so the line lags the
   // FSM by one cycle: capture at edge k drives the start bit from edge k+1.
   always_comb begin
      txNext   = UART_STOP_BIT;
      ryNext   = 1'b0;
      busyNext = 1'b0;
      case (state)
         IDLE: begin
            busyNext = SerialWriteEn;
         end
         START: begin
            txNext   = UART_START_BIT;
            busyNext = 1'b1;
         end
         DATA: begin
            txNext   = curByte[bitIdx];
            busyNext = 1'b1;
         end
`ifdef SERIAL_BLOCK_TX_PARITY_EN
         PARITY: begin
            txNext   = evenParity(curByte);
            busyNext = 1'b1;
         end
`endif
         STOP: begin
            busyNext = 1'b1;
         end
         DONE: begin
            ryNext = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Tx            <= 1'b1;
         SerialWriteRy <= 1'b0;
         Busy          <= 1'b0;
      end else begin
         Tx            <= txNext;
         SerialWriteRy <= ryNext;
         Busy          <= busyNext;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         shiftReg <= '0;
         byteIdx  <= '0;
         bitIdx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (SerialWriteEn) begin
                  shiftReg <= DataIn;
                  byteIdx  <= '0;
                  bitIdx   <= '0;
               end
            end
            START: begin
               if (tick) bitIdx <= '0;
            end
            DATA: begin
               if (tick) bitIdx <= bitIdx + 3'd1;
            end
            STOP: begin
               if (tick && SerialWriteEn && !lastByte) begin
                  byteIdx  <= byteIdx + 1'b1;
                  shiftReg <= shiftReg << UART_DATA_BITS;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
